// File: rtl/bcd_counter_n_if.sv
// rtl/bcd_counter_n_if.sv - control and display bundle for the BCD stopwatch counter
interface bcd_counter_n_if #(
    parameter int DIGITS = 4
);
    logic                  tick;
    logic                  start;
    logic                  stop;
    logic                  clear;
    logic                  lap;
    logic                  up_dn;
    logic [4*DIGITS-1:0]   digits;
    logic                  running;
    logic                  held;
    logic                  ovf;

    modport master (
        output tick, start, stop, clear, lap, up_dn,
        input  digits, running, held, ovf
    );

    modport slave (
        input  tick, start, stop, clear, lap, up_dn,
        output digits, running, held, ovf
    );
endinterface

// File: rtl/bcd_counter_n.sv
// rtl/bcd_counter_n.sv - N-digit packed-BCD up/down stopwatch counter with lap hold
module bcd_counter_n #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_counter_n_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_STOPPED,
        ST_RUNNING,
        ST_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   lap_q, lap_d;
    logic           held_q, held_d;
    logic           ovf_q, ovf_d;

    logic [W-1:0]   inc_val, dec_val, step_val;
    logic           inc_carry, dec_borrow, terminal;

    // Ripple both directions through every digit; a carry/borrow out means all 9s / all 0s.
    always_comb begin
        inc_val    = count_q;
        dec_val    = count_q;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    inc_carry = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    dec_borrow = 1'b0;
                end
            end
        end
    end

    assign step_val = bus.up_dn ? inc_val : dec_val;
    assign terminal = bus.up_dn ? inc_carry : dec_borrow;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lap_d   = lap_q;
        held_d  = held_q;
        ovf_d   = 1'b0;

        if (bus.clear) begin
            state_d = ST_STOPPED;
            count_d = '0;
            lap_d   = '0;
            held_d  = 1'b0;
        end else begin
            // Snapshot uses count_q, so a coincident tick is not reflected in the lap value.
            if (bus.lap) begin
                if (held_q) begin
                    held_d = 1'b0;
                end else begin
                    held_d = 1'b1;
                    lap_d  = count_q;
                end
            end

            unique case (state_q)
                ST_STOPPED: begin
                    if (!bus.stop && bus.start) state_d = ST_RUNNING;
                end
                ST_RUNNING: begin
                    if (bus.stop) state_d = ST_STOPPED;
                    if (bus.tick) begin
                        if (!terminal || WRAP) count_d = step_val;
                        if (terminal) begin
                            ovf_d = 1'b1;
                            if (!WRAP) state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                end
                default: state_d = ST_STOPPED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOPPED;
            count_q <= '0;
            lap_q   <= '0;
            held_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lap_q   <= lap_d;
            held_q  <= held_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.digits  = held_q ? lap_q : count_q;
    assign bus.running = (state_q == ST_RUNNING);
    assign bus.held    = held_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_bcd_counter_n.sv
// tb/tb_bcd_counter_n.sv - directed self-checking bench for bcd_counter_n
module tb_bcd_counter_n;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0, up_dn = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bcd_counter_n_if #(.DIGITS(4)) if4w ();
    bcd_counter_n_if #(.DIGITS(4)) if4s ();
    bcd_counter_n_if #(.DIGITS(1)) if1 ();
    bcd_counter_n_if #(.DIGITS(8)) if8 ();

    assign if4w.tick = tick; assign if4w.start = start; assign if4w.stop = stop;
    assign if4w.clear = clear; assign if4w.lap = lap; assign if4w.up_dn = up_dn;
    assign if4s.tick = tick; assign if4s.start = start; assign if4s.stop = stop;
    assign if4s.clear = clear; assign if4s.lap = lap; assign if4s.up_dn = up_dn;
    assign if1.tick = tick; assign if1.start = start; assign if1.stop = stop;
    assign if1.clear = clear; assign if1.lap = lap; assign if1.up_dn = up_dn;
    assign if8.tick = tick; assign if8.start = start; assign if8.stop = stop;
    assign if8.clear = clear; assign if8.lap = lap; assign if8.up_dn = up_dn;

    bcd_counter_n #(.DIGITS(4), .WRAP(1'b1)) dut4w (.clk(clk), .rst_n(rst_n), .bus(if4w));
    bcd_counter_n #(.DIGITS(4), .WRAP(1'b0)) dut4s (.clk(clk), .rst_n(rst_n), .bus(if4s));
    bcd_counter_n #(.DIGITS(1), .WRAP(1'b1)) dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    bcd_counter_n #(.DIGITS(8), .WRAP(1'b1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));

    // Inputs change just after a falling edge; outputs are read on the falling edge.
    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; @(negedge clk); clear = 1'b0;
    endtask

    task automatic pulse_tick(input logic dir);
        up_dn = dir; tick = 1'b1; @(negedge clk); tick = 1'b0;
    endtask

    task automatic run_ticks(input int n, input logic dir, output int ovf_hits);
        ovf_hits = 0;
        up_dn = dir;
        tick = 1'b1;
        repeat (n) begin
            @(negedge clk);
            if (if4w.ovf) ovf_hits++;
        end
        tick = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (if4w.digits !== 16'h0000) begin n_bad++; $display("FAIL reset_digits: got %h want 0000", if4w.digits); end
        n_cmp++; if (if4w.running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b want 0", if4w.running); end
        n_cmp++; if (if4w.held !== 1'b0) begin n_bad++; $display("FAIL reset_held: got %b want 0", if4w.held); end
        n_cmp++; if (if4w.ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", if4w.ovf); end
        n_cmp++; if (if8.digits !== 32'h0) begin n_bad++; $display("FAIL reset_digits8: got %h want 00000000", if8.digits); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_count_up();
        int hits;
        pulse_start();
        n_cmp++; if (if4w.running !== 1'b1) begin n_bad++; $display("FAIL start_running: got %b want 1", if4w.running); end
        run_ticks(1234, 1'b1, hits);
        n_cmp++; if (if4w.digits !== 16'h1234) begin n_bad++; $display("FAIL count_1234: got %h want 1234", if4w.digits); end
        n_cmp++; if (if4w.running !== 1'b1) begin n_bad++; $display("FAIL count_running: got %b want 1", if4w.running); end
        n_cmp++; if (hits !== 0) begin n_bad++; $display("FAIL count_ovf_hits: got %0d want 0", hits); end
    endtask

    task automatic test_wrap();
        int hits;
        pulse_clear();
        pulse_start();
        run_ticks(9999, 1'b1, hits);
        n_cmp++; if (if4w.digits !== 16'h9999) begin n_bad++; $display("FAIL wrap_pre: got %h want 9999", if4w.digits); end
        n_cmp++; if (hits !== 0) begin n_bad++; $display("FAIL wrap_pre_ovf: got %0d want 0", hits); end
        n_cmp++; if (if1.digits !== 4'h9) begin n_bad++; $display("FAIL wrap1_pre: got %h want 9", if1.digits); end
        n_cmp++; if (if8.digits !== 32'h00009999) begin n_bad++; $display("FAIL wrap8_pre: got %h want 00009999", if8.digits); end
        pulse_tick(1'b1);
        n_cmp++; if (if4w.digits !== 16'h0000) begin n_bad++; $display("FAIL wrap_val: got %h want 0000", if4w.digits); end
        n_cmp++; if (if4w.ovf !== 1'b1) begin n_bad++; $display("FAIL wrap_ovf: got %b want 1", if4w.ovf); end
        n_cmp++; if (if1.digits !== 4'h0) begin n_bad++; $display("FAIL wrap1_val: got %h want 0", if1.digits); end
        n_cmp++; if (if1.ovf !== 1'b1) begin n_bad++; $display("FAIL wrap1_ovf: got %b want 1", if1.ovf); end
        @(negedge clk);
        n_cmp++; if (if4w.ovf !== 1'b0) begin n_bad++; $display("FAIL wrap_ovf_one_cycle: got %b want 0", if4w.ovf); end
        pulse_tick(1'b1);
        n_cmp++; if (if4w.digits !== 16'h0001) begin n_bad++; $display("FAIL wrap_next: got %h want 0001", if4w.digits); end
        n_cmp++; if (if4w.ovf !== 1'b0) begin n_bad++; $display("FAIL wrap_next_ovf: got %b want 0", if4w.ovf); end
    endtask

    task automatic test_wide_wrap();
        pulse_clear();
        pulse_start();
        pulse_tick(1'b0);
        n_cmp++; if (if8.digits !== 32'h99999999) begin n_bad++; $display("FAIL dig8_down_wrap: got %h want 99999999", if8.digits); end
        n_cmp++; if (if8.ovf !== 1'b1) begin n_bad++; $display("FAIL dig8_down_ovf: got %b want 1", if8.ovf); end
        pulse_tick(1'b1);
        n_cmp++; if (if8.digits !== 32'h00000000) begin n_bad++; $display("FAIL dig8_up_wrap: got %h want 00000000", if8.digits); end
        n_cmp++; if (if8.ovf !== 1'b1) begin n_bad++; $display("FAIL dig8_up_ovf: got %b want 1", if8.ovf); end
        pulse_tick(1'b1);
        n_cmp++; if (if8.digits !== 32'h00000001) begin n_bad++; $display("FAIL dig8_next: got %h want 00000001", if8.digits); end
    endtask

    task automatic test_saturate();
        int hits;
        logic [15:0] exp_d [4] = '{16'h0002, 16'h0001, 16'h0000, 16'h0000};
        logic        exp_o [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        pulse_clear();
        pulse_start();
        run_ticks(3, 1'b1, hits);
        n_cmp++; if (if4s.digits !== 16'h0003) begin n_bad++; $display("FAIL sat_pre: got %h want 0003", if4s.digits); end
        for (int i = 0; i < 4; i++) begin
            pulse_tick(1'b0);
            n_cmp++; if (if4s.digits !== exp_d[i] || if4s.ovf !== exp_o[i]) begin
                n_bad++; $display("FAIL sat_step%0d: got %h/%b want %h/%b", i, if4s.digits, if4s.ovf, exp_d[i], exp_o[i]);
            end
        end
        n_cmp++; if (if4s.running !== 1'b0) begin n_bad++; $display("FAIL sat_done_running: got %b want 0", if4s.running); end
        pulse_tick(1'b0);
        n_cmp++; if (if4s.ovf !== 1'b0 || if4s.digits !== 16'h0000) begin n_bad++; $display("FAIL sat_done_tick: got %h/%b want 0000/0", if4s.digits, if4s.ovf); end
        pulse_start();
        pulse_tick(1'b1);
        n_cmp++; if (if4s.running !== 1'b0 || if4s.digits !== 16'h0000) begin n_bad++; $display("FAIL sat_done_start: got %h/%b want 0000/0", if4s.digits, if4s.running); end
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        pulse_clear();
        n_cmp++; if (if4s.running !== 1'b0 || if4s.digits !== 16'h0000) begin n_bad++; $display("FAIL sat_clear: got %h/%b want 0000/0", if4s.digits, if4s.running); end
        pulse_start();
        n_cmp++; if (if4s.running !== 1'b1) begin n_bad++; $display("FAIL sat_restart: got %b want 1", if4s.running); end
    endtask

    task automatic test_lap();
        int hits;
        pulse_clear();
        pulse_start();
        run_ticks(42, 1'b1, hits);
        lap = 1'b1; @(negedge clk); lap = 1'b0;
        n_cmp++; if (if4w.held !== 1'b1 || if4w.digits !== 16'h0042) begin n_bad++; $display("FAIL lap_freeze: got %h/%b want 0042/1", if4w.digits, if4w.held); end
        run_ticks(10, 1'b1, hits);
        n_cmp++; if (if4w.digits !== 16'h0042) begin n_bad++; $display("FAIL lap_hold: got %h want 0042", if4w.digits); end
        lap = 1'b1; @(negedge clk); lap = 1'b0;
        n_cmp++; if (if4w.held !== 1'b0 || if4w.digits !== 16'h0052) begin n_bad++; $display("FAIL lap_release: got %h/%b want 0052/0", if4w.digits, if4w.held); end
        lap = 1'b1; tick = 1'b1; up_dn = 1'b1; @(negedge clk); lap = 1'b0; tick = 1'b0;
        n_cmp++; if (if4w.held !== 1'b1 || if4w.digits !== 16'h0052) begin n_bad++; $display("FAIL lap_pretick: got %h/%b want 0052/1", if4w.digits, if4w.held); end
        lap = 1'b1; @(negedge clk); lap = 1'b0;
        n_cmp++; if (if4w.held !== 1'b0 || if4w.digits !== 16'h0053) begin n_bad++; $display("FAIL lap_after_tick: got %h/%b want 0053/0", if4w.digits, if4w.held); end
        lap = 1'b1;
        @(negedge clk);
        n_cmp++; if (if4w.held !== 1'b1) begin n_bad++; $display("FAIL lap_level_1: got %b want 1", if4w.held); end
        @(negedge clk);
        lap = 1'b0;
        n_cmp++; if (if4w.held !== 1'b0) begin n_bad++; $display("FAIL lap_level_2: got %b want 0", if4w.held); end
    endtask

    task automatic test_ctrl_priority();
        start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
        n_cmp++; if (if4w.running !== 1'b0) begin n_bad++; $display("FAIL start_stop_same: got %b want 0", if4w.running); end
        pulse_start();
        pulse_tick(1'b1);
        n_cmp++; if (if4w.digits !== 16'h0054) begin n_bad++; $display("FAIL ctrl_tick: got %h want 0054", if4w.digits); end
        clear = 1'b1; stop = 1'b1; tick = 1'b1; @(negedge clk); clear = 1'b0; stop = 1'b0; tick = 1'b0;
        n_cmp++; if (if4w.digits !== 16'h0000 || if4w.running !== 1'b0) begin n_bad++; $display("FAIL clear_stop_tick: got %h/%b want 0000/0", if4w.digits, if4w.running); end
        pulse_tick(1'b1);
        n_cmp++; if (if4w.digits !== 16'h0000) begin n_bad++; $display("FAIL stopped_tick: got %h want 0000", if4w.digits); end
    endtask

    task automatic test_reset_mid();
        int hits;
        pulse_clear();
        pulse_start();
        run_ticks(777, 1'b1, hits);
        lap = 1'b1; @(negedge clk); lap = 1'b0;
        n_cmp++; if (if4w.held !== 1'b1 || if4w.digits !== 16'h0777) begin n_bad++; $display("FAIL mid_pre: got %h/%b want 0777/1", if4w.digits, if4w.held); end
        tick = 1'b1; up_dn = 1'b1;
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (if4w.digits !== 16'h0000 || if4w.held !== 1'b0 || if4w.running !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset: got %h/%b/%b want 0000/0/0", if4w.digits, if4w.held, if4w.running);
        end
        tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        pulse_tick(1'b1);
        n_cmp++; if (if4w.digits !== 16'h0001) begin n_bad++; $display("FAIL mid_restart: got %h want 0001", if4w.digits); end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_wide_wrap();
        test_saturate();
        test_lap();
        test_ctrl_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
